// File: rtl/mux_scan_sel_pkg.sv
// Shared types and helpers for the mux_scan_sel channel selector.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_SCAN   = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_RSVD   = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_MANUAL,
    ST_SCAN,
    ST_HOLD
  } state_t;

  // Select/index width for n channels (n >= 2).
  function automatic int unsigned sel_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mux_scan_sel_if.sv
// Bus bundle for mux_scan_sel: mode/select/data in, selection status out.
// Optional macro MUX_SCAN_MASK_EN adds the per-channel enable vector ch_en.
interface mux_scan_sel_if
  import mux_scan_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 1
);
  localparam int unsigned SEL_W = sel_width(NCH);

  logic [1:0]           mode;
  logic [SEL_W-1:0]     sel_in;
  logic [NCH*WIDTH-1:0] data_in;
  logic [WIDTH-1:0]     data_out;
  logic [SEL_W-1:0]     cur_sel;
  logic [NCH-1:0]       chan_onehot;
  logic                 switch_pulse;
`ifdef MUX_SCAN_MASK_EN
  logic [NCH-1:0]       ch_en;

  modport master (output mode, sel_in, data_in, ch_en,
                  input  data_out, cur_sel, chan_onehot, switch_pulse);
  modport slave  (input  mode, sel_in, data_in, ch_en,
                  output data_out, cur_sel, chan_onehot, switch_pulse);
`else
  modport master (output mode, sel_in, data_in,
                  input  data_out, cur_sel, chan_onehot, switch_pulse);
  modport slave  (input  mode, sel_in, data_in,
                  output data_out, cur_sel, chan_onehot, switch_pulse);
`endif
endinterface

// File: rtl/mux_scan_sel_dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while enabled, ticks on the last count.
module mux_dwell_counter #(
  parameter int unsigned DWELL = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] count;

  assign tick = enable && !clear && (count == LAST);

  // Count register: clear wins over counting; wraps to 0 after the tick.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/mux_scan_sel.sv
// N-channel registered multiplexer with manual / round-robin scan / hold modes.
// Optional macro MUX_SCAN_MASK_EN enables per-channel masking via bus.ch_en.
module mux_scan_sel
  import mux_scan_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DWELL = 4
) (
  input  logic           clock,
  input  logic           reset,
  mux_scan_sel_if.slave  bus
);
  localparam int unsigned SEL_W = sel_width(NCH);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NCH - 1);

  state_t           state, state_nxt;
  logic [NCH-1:0]   en;
  logic [WIDTH-1:0] ch [NCH];
  logic [SEL_W-1:0] cur_sel, sel_next, scan_nxt, cand;
  logic             found;
  logic [WIDTH-1:0] data_q, data_nxt;
  logic [NCH-1:0]   onehot_q;
  logic             pulse_q;
  logic             cnt_clear, cnt_en, tick;

`ifdef MUX_SCAN_MASK_EN
  assign en = bus.ch_en;
`else
  assign en = '1;
`endif

  assign bus.cur_sel      = cur_sel;
  assign bus.data_out     = data_q;
  assign bus.chan_onehot  = onehot_q;
  assign bus.switch_pulse = pulse_q;

  // Unpack the flat input bus into per-channel words.
  always_comb begin
    for (int unsigned k = 0; k < NCH; k++) begin
      ch[k] = bus.data_in[k*WIDTH +: WIDTH];
    end
  end

  // Decode the requested mode; reserved encoding behaves as hold.
  always_comb begin
    state_nxt = ST_HOLD;
    case (mode_t'(bus.mode))
      MODE_MANUAL: state_nxt = ST_MANUAL;
      MODE_SCAN:   state_nxt = ST_SCAN;
      default:     state_nxt = ST_HOLD;
    endcase
  end

  assign cnt_en    = (state_nxt == ST_SCAN);
  assign cnt_clear = (state_nxt == ST_SCAN) && (state != ST_SCAN);

  mux_dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clock  (clock),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .tick   (tick)
  );

  // Next enabled channel in circular order after cur_sel; cur_sel itself is
  // visited last so a single enabled channel keeps its own selection.
  always_comb begin
    cand     = cur_sel;
    scan_nxt = cur_sel;
    found    = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cand = (cand == LAST) ? '0 : cand + SEL_W'(1);
      if (!found && en[cand]) begin
        scan_nxt = cand;
        found    = 1'b1;
      end
    end
  end

  // Channel the selection moves to at the coming edge.
  always_comb begin
    sel_next = cur_sel;
    case (state_nxt)
      ST_MANUAL: if ((32'(bus.sel_in) < NCH) && en[bus.sel_in]) sel_next = bus.sel_in;
      ST_SCAN:   if (tick) sel_next = scan_nxt;
      default:   sel_next = cur_sel;
    endcase
    data_nxt = en[sel_next] ? ch[sel_next] : '0;
  end

  // Mode state and all registered outputs, updated together each cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_MANUAL;
      cur_sel  <= '0;
      onehot_q <= NCH'(1);
      data_q   <= '0;
      pulse_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cur_sel  <= sel_next;
      onehot_q <= NCH'(1) << sel_next;
      data_q   <= data_nxt;
      pulse_q  <= (sel_next != cur_sel);
    end
  end

endmodule

// File: tb/tb_mux_scan_sel.sv
// Self-checking bench for mux_scan_sel (NCH=4, WIDTH=4, DWELL=4).
// Define MUX_SCAN_MASK_EN to also exercise the channel-mask variant.
module tb_mux_scan_sel;
  localparam int NCH   = 4;
  localparam int WIDTH = 4;
  localparam int DWELL = 4;

  logic clock;
  logic reset;

  mux_scan_sel_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();

  mux_scan_sel #(.NCH(NCH), .WIDTH(WIDTH), .DWELL(DWELL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model state: selected channel, expected outputs, previous mode
  // class (0 manual, 1 scan, 2 hold) and number of edges since scan entry.
  int m_sel, m_data, m_pulse, m_prev, m_age;

  function automatic logic [3:0] cur_en();
`ifdef MUX_SCAN_MASK_EN
    return bus.ch_en;
`else
    return 4'hF;
`endif
  endfunction

  function automatic int nxt_en(input int cur, input logic [3:0] en);
    for (int k = 1; k <= NCH; k++) begin
      if (en[(cur + k) % NCH]) return (cur + k) % NCH;
    end
    return cur;
  endfunction

  function automatic void model_edge();
    logic [3:0] en;
    int mc, old, nw;
    en = cur_en();
    if (reset) begin
      m_sel = 0; m_data = 0; m_pulse = 0; m_prev = 0; m_age = 0;
      return;
    end
    mc  = (bus.mode == 2'b00) ? 0 : (bus.mode == 2'b01) ? 1 : 2;
    old = m_sel;
    nw  = old;
    if (mc == 0) begin
      if (int'(bus.sel_in) < NCH && en[bus.sel_in]) nw = int'(bus.sel_in);
    end else if (mc == 1) begin
      if (m_prev != 1) m_age = 0;
      else begin
        m_age++;
        if (m_age % DWELL == 0) nw = nxt_en(old, en);
      end
    end
    m_prev  = mc;
    m_sel   = nw;
    m_data  = en[nw] ? int'((bus.data_in >> (nw * WIDTH)) & 16'hF) : 0;
    m_pulse = (nw != old) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    chk("cur_sel", 32'(bus.cur_sel), m_sel);
    chk("data_out", 32'(bus.data_out), m_data);
    chk("chan_onehot", 32'(bus.chan_onehot), 32'd1 << m_sel);
    chk("switch_pulse", 32'(bus.switch_pulse), m_pulse);
  endtask

  int adv_at;

  initial begin
    clock        = 1'b0;
    reset        = 1'b1;
    bus.mode     = 2'b00;
    bus.sel_in   = 2'd0;
    bus.data_in  = 16'hDCBA;
`ifdef MUX_SCAN_MASK_EN
    bus.ch_en    = 4'hF;
`endif
    m_sel = 0; m_data = 0; m_pulse = 0; m_prev = 0; m_age = 0;

    // Reset state
    step();
    chk("rst_cur_sel", 32'(bus.cur_sel), 0);
    chk("rst_data_out", 32'(bus.data_out), 0);
    chk("rst_onehot", 32'(bus.chan_onehot), 32'b0001);
    reset = 1'b0;
    step();
    chk("man0_data", 32'(bus.data_out), 32'hA);
    chk("man0_pulse", 32'(bus.switch_pulse), 0);

    // Manual select 0 -> 2, then held
    bus.sel_in = 2'd2;
    step();
    chk("man2_sel", 32'(bus.cur_sel), 2);
    chk("man2_data", 32'(bus.data_out), 32'hC);
    chk("man2_onehot", 32'(bus.chan_onehot), 32'b0100);
    chk("man2_pulse", 32'(bus.switch_pulse), 1);
    step();
    chk("man2_nopulse", 32'(bus.switch_pulse), 0);
    step();
    bus.sel_in = 2'd0;
    step();

    // Scan with wrap: entry edge plus 16 edges -> 0,1,2,3,0
    bus.mode = 2'b01;
    for (int i = 0; i < 17; i++) step();
    chk("wrap_sel", 32'(bus.cur_sel), 0);
    chk("wrap_pulse", 32'(bus.switch_pulse), 1);
    for (int i = 0; i < 6; i++) step();
    chk("mid_dwell_sel", 32'(bus.cur_sel), 1);

    // Hold with live data change on channel 1, then resume
    bus.mode    = 2'b10;
    bus.data_in = 16'hDC5A;
    step();
    chk("hold_sel", 32'(bus.cur_sel), 1);
    chk("hold_data", 32'(bus.data_out), 32'h5);
    step();
    bus.mode = 2'b01;
    adv_at = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (adv_at == 0 && bus.switch_pulse === 1'b1) adv_at = i;
    end
    chk("resume_latency", adv_at, 1 + DWELL);

    // Reset mid-scan once cur_sel reaches 3 (bounded)
    for (int i = 0; i < 40 && bus.cur_sel !== 2'd3; i++) step();
    chk("reach_sel3", 32'(bus.cur_sel), 3);
    reset = 1'b1;
    step();
    chk("midrst_sel", 32'(bus.cur_sel), 0);
    chk("midrst_pulse", 32'(bus.switch_pulse), 0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) step();

    // Reserved mode behaves as hold
    bus.mode = 2'b11;
    for (int i = 0; i < 6; i++) step();

`ifdef MUX_SCAN_MASK_EN
    // Masked scan: channels 1 and 3 only
    bus.ch_en = 4'b1010;
    bus.mode  = 2'b01;
    for (int i = 0; i < 20; i++) step();
    bus.ch_en = 4'b0000;
    step();
    chk("mask_none_data", 32'(bus.data_out), 0);
    chk("mask_none_pulse", 32'(bus.switch_pulse), 0);
    for (int i = 0; i < 5; i++) step();
    bus.ch_en  = 4'b1010;
    bus.mode   = 2'b00;
    bus.sel_in = 2'd0;
    for (int i = 0; i < 3; i++) step();
    bus.mode = 2'b10;
    bus.ch_en = 4'b0000;
    step();
    chk("mask_hold_data", 32'(bus.data_out), 0);
    bus.ch_en = 4'b1010;
    step();
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) bus.mode = 2'($urandom_range(0, 3));
      bus.sel_in = 2'($urandom);
      if ($urandom_range(0, 3) == 0) bus.data_in = 16'($urandom);
`ifdef MUX_SCAN_MASK_EN
      if ($urandom_range(0, 15) == 0) bus.ch_en = 4'($urandom);
`endif
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_scan_sel.md
Name: mux_scan_sel

Overview:
- Parametrised N-channel, W-bit registered multiplexer. Generalises the board-level 2:1 mux.
- Three modes:
  - manual select from switches;
  - automatic round-robin scan with programmable dwell time;
  - hold/freeze.
- Sits between switch/sensor input buses and LEDR/HEX display logic.
- Provides the selected data word, the current channel index, a one-hot channel indicator and a channel-change strobe.

Parameters:
- NCH, 4, number of input channels (>=2).
- WIDTH, 1, bits per channel.
- DWELL, 4, clock cycles spent on each channel in scan mode (>=1).
- SEL_W, $clog2(NCH), localparam, select/index width.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  2  00 manual, 01 scan, 10 hold, 11 treated as hold.
- sel_in  in  SEL_W  manual channel request.
- data_in  in  NCH*WIDTH  packed channels; channel k = data_in[k*WIDTH +: WIDTH].
- data_out  out  WIDTH  registered selected channel data.
- cur_sel  out  SEL_W  registered current channel index.
- chan_onehot  out  NCH  one-hot of cur_sel.
- switch_pulse  out  1  high for exactly one cycle after cur_sel changes.

Behaviour:
- Reset: synchronous, active-high; wins over all other inputs.
  - cur_sel=0, chan_onehot=1, data_out=0, switch_pulse=0.
  - dwell counter=0, state=MANUAL.
  - Reset asserted mid-scan aborts the scan; the first cycle after reset release behaves per mode.
- State machine: MANUAL/SCAN/HOLD, decoded from mode each cycle; state register tracks the previous mode.
- Entering SCAN from any other state clears the dwell counter to 0. The first advance occurs DWELL cycles after entry.
- sel_next (value cur_sel takes at the edge):
  - MANUAL: sel_in if sel_in<NCH, else cur_sel. Out-of-range requests are ignored; relevant when NCH is not a power of 2.
  - SCAN: counter counts 0..DWELL-1. At DWELL-1, sel_next=(cur_sel==NCH-1)?0:cur_sel+1 and the counter clears. Otherwise sel_next=cur_sel. DWELL=1 advances every cycle.
  - HOLD: sel_next=cur_sel. Dwell counter frozen, but cleared again on re-entry to SCAN.
- Datapath, 1-cycle latency:
  - data_out <= slice sel_next of data_in. data_out always corresponds to cur_sel on the same cycle.
  - data_out keeps tracking live input changes on the held channel in every mode.
- chan_onehot <= 1<<sel_next.
- switch_pulse <= (sel_next != cur_sel). No pulse for a manual re-select of the same channel.
- Mode change and scan-advance on the same cycle: the new mode governs.
- Arithmetic: all index math is unsigned SEL_W bits. Wrap is explicit compare to NCH-1, never a natural overflow.

Optional Feature:
- Macro MUX_SCAN_MASK_EN.
- When defined:
  - Extra port ch_en, in, NCH bits, per-channel enable.
  - SCAN advances to the next enabled channel in circular order after cur_sel; cur_sel itself is included last.
  - MANUAL requests for a disabled channel are ignored.
  - If ch_en==0: cur_sel holds, data_out forced to 0, switch_pulse=0.
  - If the current channel becomes disabled in HOLD: data_out forced to 0 until re-enabled.
- When undefined: no ch_en port; all channels are treated as enabled; logic identical to the above with ch_en all-ones.

Decomposition:
- Package mux_scan_pkg:
  - mode typedef (2-bit enum MODE_MANUAL, MODE_SCAN, MODE_HOLD, MODE_RSVD);
  - state typedef;
  - helper function for the SEL_W clog2.
- One natural sub-module: mux_dwell_counter.
  - Parameter DWELL.
  - Inputs clock, reset, clear, enable.
  - Output tick, high on the count==DWELL-1 cycle.
  - Reused later by display-blink logic.

Test Plan:
- Reset: NCH=4, WIDTH=4, data_in=16'hDCBA, reset 1 cycle -> cur_sel=0, data_out=0, chan_onehot=4'b0001; next cycle in manual with sel_in=0 -> data_out=4'hA, switch_pulse=0.
- Manual select: sel_in 0->2 -> one cycle later cur_sel=2, data_out=4'hC, chan_onehot=4'b0100, switch_pulse high exactly 1 cycle; sel_in held at 2 -> no further pulses.
- Scan wrap: mode=01, DWELL=4 -> cur_sel sequence 0,1,2,3,0 changing every 4 cycles, switch_pulse on each change, 3->0 wrap correct.
- Hold/resume: mode 01->10 mid-dwell with cur_sel=1; data_in slice 1 changed to 4'h5 -> cur_sel frozen, data_out=4'h5 next cycle; back to 01 -> first advance exactly 4 cycles later.
- Reset mid-scan: assert reset with cur_sel=3 -> cur_sel=0, counter cleared, switch_pulse=0 on the following cycle.
- Mask (MUX_SCAN_MASK_EN): ch_en=4'b1010 in scan -> sequence 1,3,1,3; ch_en=0 -> data_out=0 and cur_sel held; manual sel_in=0 with ch_en[0]=0 -> ignored.
